// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu -- load/store unit between a CPU request port and a single-port
// word-wide data memory with combinational read and clocked write.
//
// A request is accepted in IDLE (Req_Valid & Req_Ready). Every request is
// then answered by a one-cycle Rsp_Valid pulse in RESP:
//   load                  : IDLE -> READ  -> RESP
//   word store            : IDLE -> WRITE -> RESP
//   subword store (RMW)   : IDLE -> READ  -> WRITE -> RESP
//   misaligned / reserved : IDLE -> RESP  (Rsp_Err=1, no memory write)
//
// Ports
//   Clk, Rst_n            clock, asynchronous active-low reset
//   Req_Valid/Req_Ready   request handshake (Ready only in IDLE)
//   Req_Write             1 = store, 0 = load
//   Req_Size              00 byte, 01 half, 10 word, 11 reserved
//   Req_Signed            sign-extend subword loads
//   Req_Addr              byte address (ADDRESS_WIDTH+2 bits)
//   Req_WData             store data, right-aligned
//   Rsp_Valid             one-cycle completion pulse
//   Rsp_RData             load result, 0 for stores and errors
//   Rsp_Err               misaligned/unsupported, qualified by Rsp_Valid
//   Mem_Address           word address to memory (registered)
//   Mem_WriteData         word written to memory (registered)
//   Mem_MemWrite          memory write strobe (registered)
//   Mem_MemData           combinational read data from memory
//
// Build option
//   DMEM_LSU_SUBWORD_EN   when defined, byte/half loads (lane extract plus
//                         sign/zero extension) and byte/half stores by
//                         read-modify-write are supported. When undefined,
//                         only aligned word accesses are legal.
// -----------------------------------------------------------------------------
module dmem_lsu #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Req_Valid,
    output logic                     Req_Ready,
    input  logic                     Req_Write,
    input  logic [1:0]               Req_Size,
    input  logic                     Req_Signed,
    input  logic [ADDRESS_WIDTH+1:0] Req_Addr,
    input  logic [DATA_WIDTH-1:0]    Req_WData,
    output logic                     Rsp_Valid,
    output logic [DATA_WIDTH-1:0]    Rsp_RData,
    output logic                     Rsp_Err,
    output logic [ADDRESS_WIDTH-1:0] Mem_Address,
    output logic [DATA_WIDTH-1:0]    Mem_WriteData,
    output logic                     Mem_MemWrite,
    input  logic [DATA_WIDTH-1:0]    Mem_MemData
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Goes high on the first clock edge after reset release; keeps Req_Ready
    // low while reset is asserted even though the state register sits in IDLE.
    logic run_q;

    logic                     accept;
    logic                     req_err;
    logic [ADDRESS_WIDTH-1:0] mem_address_q;
    logic [DATA_WIDTH-1:0]    mem_writedata_q;
    logic                     mem_memwrite_q;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q;
    logic                     rsp_err_q;
    logic [DATA_WIDTH-1:0]    load_data;

    assign Req_Ready = run_q && (state == IDLE);
    assign accept    = Req_Valid && Req_Ready;
    assign Rsp_Valid = (state == RESP);

    assign Rsp_RData     = rsp_rdata_q;
    assign Rsp_Err       = rsp_err_q;
    assign Mem_Address   = mem_address_q;
    assign Mem_WriteData = mem_writedata_q;
    assign Mem_MemWrite  = mem_memwrite_q;

`ifdef DMEM_LSU_SUBWORD_EN
    // Fields of the accepted request needed after the accept cycle.
    typedef struct packed {
        logic                  write;
        logic [1:0]            size;
        logic                  sign;
        logic [1:0]            offset;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    req_t                  req_q;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] merge_data;

    always_comb begin
        req_err = 1'b0;
        case (Req_Size)
            SIZE_BYTE: req_err = 1'b0;
            SIZE_HALF: req_err = Req_Addr[0];
            SIZE_WORD: req_err = (Req_Addr[1:0] != 2'b00);
            default:   req_err = 1'b1;
        endcase
    end

    // Little-endian lanes: offset 0 is bits 7:0, halfword at offset 2 is 31:16.
    always_comb begin
        byte_lane = Mem_MemData[{req_q.offset, 3'b000} +: 8];
        half_lane = Mem_MemData[{req_q.offset[1], 4'b0000} +: 16];
        load_data = Mem_MemData;
        case (req_q.size)
            SIZE_BYTE: load_data = {{(DATA_WIDTH-8){req_q.sign & byte_lane[7]}}, byte_lane};
            SIZE_HALF: load_data = {{(DATA_WIDTH-16){req_q.sign & half_lane[15]}}, half_lane};
            default:   load_data = Mem_MemData;
        endcase
    end

    // Read-modify-write merge: only the addressed lane(s) take store data.
    always_comb begin
        merge_data = Mem_MemData;
        if (req_q.size == SIZE_BYTE) begin
            merge_data[{req_q.offset, 3'b000} +: 8] = req_q.wdata[7:0];
        end else if (req_q.size == SIZE_HALF) begin
            merge_data[{req_q.offset[1], 4'b0000} +: 16] = req_q.wdata[15:0];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= '{write:  Req_Write,
                       size:   Req_Size,
                       sign:   Req_Signed,
                       offset: Req_Addr[1:0],
                       wdata:  Req_WData};
        end
    end
`else
    // Word-only build: anything but an aligned word access is an error, and
    // the sign-extension request has no meaning.
    logic unused_signed;
    assign unused_signed = Req_Signed;

    assign req_err   = (Req_Size != SIZE_WORD) || (Req_Addr[1:0] != 2'b00);
    assign load_data = Mem_MemData;
`endif

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // update from the same pre-edge values, matching the hardware.
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // next_state unassigned, which would infer a latch.
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        next_state = RESP;
                    end else if (!Req_Write) begin
                        next_state = READ;
                    end else begin
`ifdef DMEM_LSU_SUBWORD_EN
                        next_state = (Req_Size == SIZE_WORD) ? WRITE : READ;
`else
                        next_state = WRITE;
`endif
                    end
                end
            end
            READ: begin
`ifdef DMEM_LSU_SUBWORD_EN
                next_state = req_q.write ? WRITE : RESP;
`else
                next_state = RESP;
`endif
            end
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and memory-side registers. The write strobe is registered from
    // next_state so it is high for exactly the WRITE cycle, and the async reset
    // drops it immediately if reset hits mid-write.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            run_q           <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            mem_memwrite_q  <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            run_q          <= 1'b1;
            mem_memwrite_q <= (next_state == WRITE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_address_q   <= Req_Addr[ADDRESS_WIDTH+1:2];
                        mem_writedata_q <= Req_WData;
                        rsp_rdata_q     <= '0;
                        rsp_err_q       <= req_err;
                    end
                end
                READ: begin
`ifdef DMEM_LSU_SUBWORD_EN
                    if (req_q.write) begin
                        mem_writedata_q <= merge_data;
                    end else begin
                        rsp_rdata_q <= load_data;
                    end
`else
                    rsp_rdata_q <= load_data;
`endif
                end
                RESP: begin
                    // Response fields are only meaningful during RESP.
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu -- self-checking bench for dmem_lsu.
// A driver issues directed requests and pushes the expected response (data,
// error flag, cycle of Rsp_Valid) into a queue; a monitor pops and compares on
// every Rsp_Valid. A behavioural word memory sits on the Mem_* port.
// Works with or without DMEM_LSU_SUBWORD_EN defined.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

    localparam int AW = 16;

    logic          Clk;
    logic          Rst_n;
    logic          Req_Valid;
    logic          Req_Ready;
    logic          Req_Write;
    logic [1:0]    Req_Size;
    logic          Req_Signed;
    logic [AW+1:0] Req_Addr;
    logic [31:0]   Req_WData;
    logic          Rsp_Valid;
    logic [31:0]   Rsp_RData;
    logic          Rsp_Err;
    logic [AW-1:0] Mem_Address;
    logic [31:0]   Mem_WriteData;
    logic          Mem_MemWrite;
    logic [31:0]   Mem_MemData;

    dmem_lsu #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Req_Valid     (Req_Valid),
        .Req_Ready     (Req_Ready),
        .Req_Write     (Req_Write),
        .Req_Size      (Req_Size),
        .Req_Signed    (Req_Signed),
        .Req_Addr      (Req_Addr),
        .Req_WData     (Req_WData),
        .Rsp_Valid     (Rsp_Valid),
        .Rsp_RData     (Rsp_RData),
        .Rsp_Err       (Rsp_Err),
        .Mem_Address   (Mem_Address),
        .Mem_WriteData (Mem_WriteData),
        .Mem_MemWrite  (Mem_MemWrite),
        .Mem_MemData   (Mem_MemData)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- memory model ----------------
    logic [31:0]   mem [0:(1<<AW)-1];
    int            wr_count = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [31:0]   last_wr_data = '0;

    assign Mem_MemData = mem[Mem_Address];

    always @(posedge Clk) begin
        if (Mem_MemWrite) begin
            mem[Mem_Address] <= Mem_WriteData;
            wr_count         <= wr_count + 1;
            last_wr_addr     <= Mem_Address;
            last_wr_data     <= Mem_WriteData;
        end
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          rsp_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   memwrite_cycles = 0;
    int   accept_count    = 0;
    int   last_accept_cyc = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (Mem_MemWrite) memwrite_cycles++;
            if (Req_Valid && Req_Ready) accept_count++;
            if (Rsp_Valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_rsp: Rsp_Valid with rdata 0x%08h err %0b, no response expected (t=%0t)",
                             Rsp_RData, Rsp_Err, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_rdata",   Rsp_RData, mon_e.rdata);
                    check("rsp_err",     {31'b0, Rsp_Err}, {31'b0, mon_e.err});
                    check("rsp_latency", 32'(cyc), 32'(mon_e.rsp_cyc));
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Presents a request and holds it until accepted; returns 1 ns after the
    // accepting edge with Req_Valid still high.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [AW+1:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat, input bit expect_rsp);
        int  waited = 0;
        bit  done   = 0;
        Req_Valid  = 1'b1;
        Req_Write  = wr;
        Req_Size   = sz;
        Req_Signed = sgn;
        Req_Addr   = addr;
        Req_WData  = wd;
        while (!done) begin
            @(negedge Clk);
            if (Req_Ready) begin
                last_accept_cyc = cyc;
                if (expect_rsp) exp_q.push_back('{exp_rdata, exp_err, cyc + lat});
                done = 1;
            end else begin
                waited++;
                if (waited > 20) begin
                    checks++;
                    fails++;
                    $display("FAIL accept_timeout: Req_Ready low for %0d cycles, required high", waited);
                    done = 1;
                end
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge Clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL rsp_timeout: %0d responses outstanding, 0 required", exp_q.size());
            exp_q.delete();
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic txn(input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [AW+1:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        issue(wr, sz, sgn, addr, wd, exp_rdata, exp_err, lat, 1'b1);
        Req_Valid = 1'b0;
        wait_drain();
    endtask

    // Global guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int          wc0;
        int          mw0;
        int          ac0;
        int          a0;
        int          a1;
        int          a2;
        logic [31:0] mem10_exp;

        Rst_n      = 1'b0;
        Req_Valid  = 1'b0;
        Req_Write  = 1'b0;
        Req_Size   = 2'b10;
        Req_Signed = 1'b0;
        Req_Addr   = '0;
        Req_WData  = '0;

        // Reset state, visible without any clock edge.
        #3;
        check("rst_ready",     {31'b0, Req_Ready},    32'd0);
        check("rst_rsp_valid", {31'b0, Rsp_Valid},    32'd0);
        check("rst_rdata",     Rsp_RData,             32'd0);
        check("rst_err",       {31'b0, Rsp_Err},      32'd0);
        check("rst_memwrite",  {31'b0, Mem_MemWrite}, 32'd0);
        check("rst_mem_addr",  {16'b0, Mem_Address},  32'd0);
        check("rst_mem_wdata", Mem_WriteData,         32'd0);

        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("ready_before_edge", {31'b0, Req_Ready}, 32'd0);
        @(posedge Clk);
        #1;
        check("ready_after_edge",  {31'b0, Req_Ready}, 32'd1);

        // Word store then word load at byte address 0x0010 (word 4).
        wc0 = wr_count;
        mw0 = memwrite_cycles;
        txn(1'b1, 2'b10, 1'b0, 18'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        check("st_write_count", 32'(wr_count - wc0), 32'd1);
        check("st_strobe_cycles", 32'(memwrite_cycles - mw0), 32'd1);
        check("st_wr_addr", {16'b0, last_wr_addr}, 32'h0000_0004);
        check("st_wr_data", last_wr_data, 32'hDEADBEEF);
        mem10_exp = 32'hDEADBEEF;

        issue(1'b0, 2'b10, 1'b0, 18'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
        Req_Valid = 1'b0;
        check("ld_mem_addr", {16'b0, Mem_Address}, 32'h0000_0004);
        check("ld_no_strobe", {31'b0, Mem_MemWrite}, 32'd0);
        wait_drain();

        // Fill two more words for the back-to-back test.
        txn(1'b1, 2'b10, 1'b0, 18'h0014, 32'h0BADF00D, 32'h0, 1'b0, 2);
        txn(1'b1, 2'b10, 1'b0, 18'h0018, 32'hCAFEBABE, 32'h0, 1'b0, 2);

        // Req_Valid held high across three word loads.
        ac0 = accept_count;
        issue(1'b0, 2'b10, 1'b0, 18'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
        a0 = last_accept_cyc;
        issue(1'b0, 2'b10, 1'b0, 18'h0014, 32'h0, 32'h0BADF00D, 1'b0, 2, 1'b1);
        a1 = last_accept_cyc;
        issue(1'b0, 2'b10, 1'b0, 18'h0018, 32'h0, 32'hCAFEBABE, 1'b0, 2, 1'b1);
        a2 = last_accept_cyc;
        Req_Valid = 1'b0;
        wait_drain();
        check("b2b_accepts", 32'(accept_count - ac0), 32'd3);
        check("b2b_gap_01", 32'(a1 - a0), 32'd3);
        check("b2b_gap_12", 32'(a2 - a1), 32'd3);

        // Error requests: no memory write at all.
        wc0 = wr_count;
        mw0 = memwrite_cycles;
        txn(1'b0, 2'b01, 1'b0, 18'h0013, 32'h0, 32'h0, 1'b1, 1);          // misaligned half load
        txn(1'b1, 2'b10, 1'b0, 18'h0012, 32'h12345678, 32'h0, 1'b1, 1);   // misaligned word store
        txn(1'b1, 2'b11, 1'b0, 18'h0010, 32'h87654321, 32'h0, 1'b1, 1);   // reserved size
`ifndef DMEM_LSU_SUBWORD_EN
        txn(1'b1, 2'b00, 1'b0, 18'h0010, 32'h000000AB, 32'h0, 1'b1, 1);   // byte store unsupported
        txn(1'b0, 2'b01, 1'b0, 18'h0012, 32'h0, 32'h0, 1'b1, 1);          // half load unsupported
`endif
        check("err_no_write", 32'(wr_count - wc0), 32'd0);
        check("err_no_strobe", 32'(memwrite_cycles - mw0), 32'd0);
        check("err_mem_unchanged", mem[4], 32'hDEADBEEF);

`ifdef DMEM_LSU_SUBWORD_EN
        // Subword read-modify-write and extension.
        txn(1'b1, 2'b10, 1'b0, 18'h0010, 32'h11223344, 32'h0, 1'b0, 2);
        mw0 = memwrite_cycles;
        txn(1'b1, 2'b00, 1'b0, 18'h0011, 32'h123456AB, 32'h0, 1'b0, 3);
        check("sb_strobe_cycles", 32'(memwrite_cycles - mw0), 32'd1);
        check("sb_mem_word", mem[4], 32'h1122AB44);
        txn(1'b0, 2'b00, 1'b1, 18'h0011, 32'h0, 32'hFFFFFFAB, 1'b0, 2);
        txn(1'b0, 2'b00, 1'b0, 18'h0011, 32'h0, 32'h000000AB, 1'b0, 2);
        txn(1'b1, 2'b01, 1'b0, 18'h0012, 32'h7777BEEF, 32'h0, 1'b0, 3);
        check("sh_mem_word", mem[4], 32'hBEEFAB44);
        txn(1'b0, 2'b01, 1'b1, 18'h0012, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
        txn(1'b0, 2'b01, 1'b0, 18'h0010, 32'h0, 32'h0000AB44, 1'b0, 2);
        txn(1'b0, 2'b00, 1'b1, 18'h0013, 32'h0, 32'hFFFFFFBE, 1'b0, 2);
        txn(1'b0, 2'b00, 1'b1, 18'h0010, 32'h0, 32'h00000044, 1'b0, 2);
        mem10_exp = 32'hBEEFAB44;
`endif

        // Reset asserted during the WRITE cycle of a word store.
        wc0 = wr_count;
        issue(1'b1, 2'b10, 1'b0, 18'h0010, 32'h55AA55AA, 32'h0, 1'b0, 2, 1'b0);
        Req_Valid = 1'b0;
        check("mid_wr_strobe_high", {31'b0, Mem_MemWrite}, 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("mid_wr_strobe_drop", {31'b0, Mem_MemWrite}, 32'd0);
        check("mid_wr_ready",       {31'b0, Req_Ready},    32'd0);
        check("mid_wr_rsp_valid",   {31'b0, Rsp_Valid},    32'd0);
        check("mid_wr_mem_wdata",   Mem_WriteData,         32'd0);
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("rel_ready_low", {31'b0, Req_Ready}, 32'd0);
        @(posedge Clk);
        #1;
        check("rel_ready_high", {31'b0, Req_Ready}, 32'd1);
        check("rel_no_write", 32'(wr_count - wc0), 32'd0);
        check("rel_mem_word", mem[4], mem10_exp);

        // Normal operation after the aborted request.
        txn(1'b0, 2'b10, 1'b0, 18'h0010, 32'h0, mem10_exp, 1'b0, 2);

        repeat (3) @(posedge Clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
